output_sender: RTL
==================

// Module: output_sender
// PURPOSE
//  Transmit side of the host UART link. Accepts 32-bit words (or single bytes) from the core's
//  output path and buffers them in a word FIFO. Serialises each entry onto UART_TX as 8N1 frames.
//  A full word is sent MSB byte first ([31:24],[23:16],[15:8],[7:0]), matching the byte order the
//  loader uses to assemble words on the receive side.
// PARAMETERS
//  CLK_PER_BIT      868  clock cycles per UART bit (100 MHz / 115200); must be >= 2
//  OUT_FIFO_SIZE    1024 FIFO depth in entries; power of two
//  LOG_OUT_FIFO     10   log2(OUT_FIFO_SIZE)
// PORTS
//  CLK          in  1             system clock, all logic on rising edge
//  RSTN         in  1             asynchronous active-low reset
//  push         in  1             enqueue request, sampled each cycle
//  push_data    in  32            data to enqueue
//  push_byte    in  1             1: entry sends only push_data[7:0] (one frame); 0: sends four frames
//  full         out 1             FIFO holds OUT_FIFO_SIZE entries
//  queue_count  out LOG_OUT_FIFO+1 entries currently in FIFO, excluding the one being sent
//  busy         out 1             FIFO non-empty or a frame in progress
//  overflow     out 1             sticky: a push arrived while full; cleared only by reset
//  UART_TX      out 1             serial line, idle high
// BEHAVIOUR
//  Reset (RSTN=0, async): UART_TX=1, full=0, queue_count=0, busy=0, overflow=0.
//   FIFO pointers=0, FSM=IDLE. A reset mid-frame aborts the frame and drops all queued entries.
//   The line is high from the reset edge onward.
//  FIFO: each entry is {push_byte, push_data} (33 bits). Write/read pointers are LOG_OUT_FIFO+1
//   bits and wrap modulo 2*OUT_FIFO_SIZE. full = (count==OUT_FIFO_SIZE).
//  Push while full: the entry is dropped and overflow <= 1. This applies even if a pop happens
//   in the same cycle; full is judged on the pre-edge count.
//  Push and pop in the same cycle when not full: both take effect and count is unchanged.
//  FSM states: IDLE, LOAD, START, DATA, STOP.
//   IDLE:  if FIFO non-empty -> LOAD.
//   LOAD (1 cycle): pop the head entry into the shift word. byte_idx <= push_byte ? 3 : 0.
//          Go to START.
//   START: drive 0 for CLK_PER_BIT cycles, then go to DATA with bit_idx=0.
//   DATA:  drive the current byte bit[bit_idx], LSB first, each bit for CLK_PER_BIT cycles.
//          After bit 7 -> STOP.
//   STOP:  drive 1 for CLK_PER_BIT cycles. Then:
//          if byte_idx<3: byte_idx+1 and go to START, with no idle gap inside a word.
//          Otherwise go to LOAD if FIFO non-empty, else IDLE.
//  Current byte = shift word byte (3-byte_idx): byte_idx 0 -> [31:24], 3 -> [7:0].
//  Latency: push at edge n into an empty idle block -> LOAD at n+1 -> UART_TX falls at edge n+2.
//  One word = 4*10*CLK_PER_BIT cycles, plus 1 LOAD cycle between entries.
//  The bit counter counts 0..CLK_PER_BIT-1. UART_TX is registered (glitch-free).
//  busy = (state!=IDLE) | (count!=0).
// TESTING (sim with CLK_PER_BIT=4, OUT_FIFO_SIZE=4)
//  1. Reset -> UART_TX=1, busy=0, full=0, overflow=0 for 20 cycles.
//  2. Push 0x12345678 with push_byte=0.
//     -> decode frames 0x12,0x34,0x56,0x78 with start bits low and stop bits high.
//     -> start edge at cycle +2 after push; 160 cycles total; busy falls after the last stop bit.
//  3. Push 0x000000A5 with push_byte=1 -> exactly one frame 0xA5 (bits 1,0,1,0,0,1,0,1 LSB first)
//     -> then IDLE.
//  4. Push 6 words back-to-back while idle. Entry 1 is popped at the LOAD cycle, so 5 push
//     cycles hit the FIFO.
//     -> full=1 after the 5th accepted entry; 6th push dropped; overflow=1.
//     -> exactly 5 words appear on the line, in push order.
//  5. Keep the FIFO at count=2. Push one entry while a pop (LOAD) occurs in the same cycle.
//     -> queue_count stays 2; no overflow.
//  6. Assert RSTN=0 mid-way through the DATA bits of byte 2, with 2 entries queued.
//     -> UART_TX=1 immediately; queue_count=0.
//     -> after release, no further frames are sent without new pushes.

Source files
------------

// File: rtl/output_sender.sv
// rtl/output_sender.sv - UART transmit path: word FIFO feeding an 8N1 serialiser, MSB byte first.
module output_sender #(
    parameter int CLK_PER_BIT   = 868,
    parameter int OUT_FIFO_SIZE = 1024,
    parameter int LOG_OUT_FIFO  = 10
) (
    input  logic                  CLK,
    input  logic                  RSTN,
    input  logic                  push,
    input  logic [31:0]           push_data,
    input  logic                  push_byte,
    output logic                  full,
    output logic [LOG_OUT_FIFO:0] queue_count,
    output logic                  busy,
    output logic                  overflow,
    output logic                  UART_TX
);

    localparam int                    CNT_W      = (CLK_PER_BIT > 1) ? $clog2(CLK_PER_BIT) : 1;
    localparam logic [CNT_W-1:0]      CNT_LAST   = CNT_W'(CLK_PER_BIT - 1);
    localparam logic [LOG_OUT_FIFO:0] FULL_COUNT = (LOG_OUT_FIFO + 1)'(OUT_FIFO_SIZE);

    typedef enum logic [2:0] {IDLE, LOAD, START, DATA, STOP} state_t;

    state_t                  state;
    logic [32:0]             mem [OUT_FIFO_SIZE];
    logic [LOG_OUT_FIFO:0]   wr_ptr;
    logic [LOG_OUT_FIFO:0]   rd_ptr;
    logic [LOG_OUT_FIFO:0]   count;
    logic [32:0]             head;
    logic [31:0]             shift_word;
    logic [1:0]              byte_idx;
    logic [2:0]              bit_idx;
    logic [CNT_W-1:0]        cnt;
    logic [7:0]              cur_byte;
    logic                    do_push;
    logic                    do_pop;
    logic                    bit_done;

    // Pointers carry one extra bit so full and empty are distinguishable.
    assign count       = wr_ptr - rd_ptr;
    assign full        = (count == FULL_COUNT);
    assign queue_count = count;
    assign busy        = (state != IDLE) || (count != '0);
    assign do_push     = push && !full;
    assign do_pop      = (state == LOAD);
    assign head        = mem[rd_ptr[LOG_OUT_FIFO-1:0]];
    assign bit_done    = (cnt == CNT_LAST);

    always_comb begin
        cur_byte = shift_word[31:24];
        case (byte_idx)
            2'd0:    cur_byte = shift_word[31:24];
            2'd1:    cur_byte = shift_word[23:16];
            2'd2:    cur_byte = shift_word[15:8];
            default: cur_byte = shift_word[7:0];
        endcase
    end

    always_ff @(posedge CLK) begin
        if (do_push) begin
            mem[wr_ptr[LOG_OUT_FIFO-1:0]] <= {push_byte, push_data};
        end
    end

    // A push while full is lost even if the serialiser pops in the same cycle.
    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            overflow <= 1'b0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            if (push && full) begin
                overflow <= 1'b1;
            end
        end
    end

    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            state      <= IDLE;
            UART_TX    <= 1'b1;
            shift_word <= '0;
            byte_idx   <= '0;
            bit_idx    <= '0;
            cnt        <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (count != '0) begin
                        state <= LOAD;
                    end
                end
                LOAD: begin
                    // Single-byte entries start at the last byte slot so only [7:0] is sent.
                    shift_word <= head[31:0];
                    byte_idx   <= head[32] ? 2'd3 : 2'd0;
                    cnt        <= '0;
                    UART_TX    <= 1'b0;
                    state      <= START;
                end
                START: begin
                    if (bit_done) begin
                        cnt     <= '0;
                        bit_idx <= '0;
                        UART_TX <= cur_byte[0];
                        state   <= DATA;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                DATA: begin
                    if (bit_done) begin
                        cnt <= '0;
                        if (bit_idx == 3'd7) begin
                            UART_TX <= 1'b1;
                            state   <= STOP;
                        end else begin
                            bit_idx <= bit_idx + 3'd1;
                            UART_TX <= cur_byte[bit_idx + 3'd1];
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                STOP: begin
                    if (bit_done) begin
                        cnt <= '0;
                        if (byte_idx != 2'd3) begin
                            byte_idx <= byte_idx + 2'd1;
                            UART_TX  <= 1'b0;
                            state    <= START;
                        end else if (count != '0) begin
                            state <= LOAD;
                        end else begin
                            state <= IDLE;
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: begin
                    state   <= IDLE;
                    UART_TX <= 1'b1;
                end
            endcase
        end
    end

endmodule
